// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit shift register: bidirectional shift, rotate, parallel load,
// synchronous clear, plus a shift counter that emits a one-cycle frame_done on wrap.
module univ_shift_reg #(
    parameter int              WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int             CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_lsb,
    input  logic             sin_msb,
    input  logic [WIDTH-1:0] pdin,
    output logic [WIDTH-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic [CW-1:0]    cnt,
    output logic             frame_done
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_SHL  = 3'b001,
        MODE_SHR  = 3'b010,
        MODE_ROL  = 3'b011,
        MODE_ROR  = 3'b100,
        MODE_LOAD = 3'b101,
        MODE_CLR  = 3'b110,
        MODE_RSVD = 3'b111
    } mode_e;

    if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
        $error("univ_shift_reg: WIDTH must be in 2..64");
    end

    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    r_cnt;
    logic             r_frame_done;

    logic [WIDTH-1:0] w_q_next;
    logic             w_is_shift;
    logic             w_cnt_clr;
    logic             w_wrap;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_q_next   = r_q;
        w_is_shift = 1'b0;
        w_cnt_clr  = 1'b0;
        case (mode_e'(mode))
            MODE_SHL: begin
                w_q_next   = {r_q[WIDTH-2:0], sin_lsb};
                w_is_shift = 1'b1;
            end
            MODE_SHR: begin
                w_q_next   = {sin_msb, r_q[WIDTH-1:1]};
                w_is_shift = 1'b1;
            end
            MODE_ROL: begin
                w_q_next   = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                w_is_shift = 1'b1;
            end
            MODE_ROR: begin
                w_q_next   = {r_q[0], r_q[WIDTH-1:1]};
                w_is_shift = 1'b1;
            end
            MODE_LOAD: begin
                w_q_next  = pdin;
                w_cnt_clr = 1'b1;
            end
            MODE_CLR: begin
                w_q_next  = '0;
                w_cnt_clr = 1'b1;
            end
            default: ;  // HOLD and the reserved code keep q and cnt unchanged
        endcase
    end

    // A shift landing on the last count position closes the frame.
    assign w_wrap = en && w_is_shift && (r_cnt == CW'(WIDTH - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q          <= RESET_VAL;
            r_cnt        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_wrap;
            if (en) begin
                r_q <= w_q_next;
                if (w_cnt_clr || w_wrap) begin
                    r_cnt <= '0;
                end else if (w_is_shift) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign q          = r_q;
    assign sout_msb   = r_q[WIDTH-1];
    assign sout_lsb   = r_q[0];
    assign cnt        = r_cnt;
    assign frame_done = r_frame_done;

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal shift register. Generalises the fixed 4-bit serial-in/serial-out shifter to WIDTH bits.
- Adds bidirectional shift, rotate, parallel load and synchronous clear.
- Provides a shift counter and a frame-done pulse, so serial links and serializers can track word boundaries.
- Sits in datapath and serial-interface logic wherever a configurable serializer/deserializer is needed.

Parameters:
- WIDTH, 4, register width in bits; legal range 2..64.
- RESET_VAL, 0, value loaded into q on rst; WIDTH bits wide.

Ports:
- clk  input  1  clock, rising-edge active
- rst  input  1  reset, asynchronous, active-high
- en  input  1  operation enable; when 0, all state holds
- mode  input  3  operation select (encoding below)
- sin_lsb  input  1  serial input entering at bit 0 during SHL
- sin_msb  input  1  serial input entering at bit WIDTH-1 during SHR
- pdin  input  WIDTH  parallel load data
- q  output  WIDTH  register contents
- sout_msb  output  1  q[WIDTH-1], combinational from q
- sout_lsb  output  1  q[0], combinational from q
- cnt  output  CW  shifts since last load/clear/wrap; CW = $clog2(WIDTH+1)
- frame_done  output  1  registered one-cycle pulse after WIDTH shifts

Behaviour:
- Clock and reset: reset rst, asynchronous, active-high; clock clk.
- Reset values while rst is high: q = RESET_VAL, cnt = 0, frame_done = 0. Reset asserted mid-operation aborts immediately; no partial shift completes.
- All state updates occur on the rising edge of clk, and only when en = 1. With en = 0: q and cnt hold, frame_done = 0.
- mode encoding (applies when en = 1):
  - 000 HOLD: q holds, cnt holds.
  - 001 SHL: q <= {q[WIDTH-2:0], sin_lsb}.
  - 010 SHR: q <= {sin_msb, q[WIDTH-1:1]}.
  - 011 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 100 ROR: q <= {q[0], q[WIDTH-1:1]}.
  - 101 LOAD: q <= pdin, cnt <= 0.
  - 110 CLR: q <= 0 (not RESET_VAL), cnt <= 0.
  - 111 reserved: behaves exactly as HOLD.
- Shift ops: SHL, SHR, ROL and ROR. Each enabled shift op increments cnt.
- Counter wrap: if cnt == WIDTH-1 and a shift op executes, then cnt <= 0 and frame_done <= 1 for the following cycle only.
- frame_done is 0 in every other cycle, including HOLD, LOAD, CLR and en = 0 cycles.
- Latency:
  - q updates one edge after the op is sampled; sout_* follow q with no extra delay.
  - Serial data entering at sin_lsb appears at sout_msb after WIDTH enabled SHL edges. Same for sin_msb to sout_lsb under SHR.
- Mixing shift directions between loads is legal. cnt counts total shift ops regardless of direction.
- cnt never exceeds WIDTH-1 in steady state; value WIDTH is unreachable.
- No combinational path from any input to any output. sout_* depend on q only.

Test Plan:
- Basic SHL (WIDTH=4): rst pulse, then SHL with sin_lsb = 1,0,1,1 on 4 edges.
  - q goes 0001, 0010, 0101, 1011.
  - frame_done = 1 in the cycle after the 4th edge, with cnt = 0.
  - Continued SHL with sin_lsb = 0 gives sout_msb = 1,0,1,1 over the next 4 edges.
- LOAD and rotate: LOAD pdin = 4'b1010 -> q = 1010, cnt = 0.
  - ROL -> 0101, then ROR -> 1010.
  - cnt = 2 afterwards; frame_done stays 0.
- SHR: q = 0000, SHR with sin_msb = 1 for 3 edges -> q = 1110, sout_lsb = 0, cnt = 3.
  - One more SHR with sin_msb = 0 -> q = 0111, frame_done pulses, cnt = 0.
- Enable, hold and reserved mode:
  - With q = 0110, en = 0 and mode = SHL for 3 edges -> q = 0110 and cnt unchanged.
  - mode = 111 with en = 1 -> identical hold behaviour.
- Async reset mid-frame: RESET_VAL = 4'b1001, after 2 SHL ops assert rst between edges.
  - q = 1001 and cnt = 0 immediately, without waiting for an edge.
  - frame_done = 0; normal counting resumes after release.
- CLR and wide instance:
  - CLR after 3 shifts -> q = 0, cnt = 0, no frame_done.
  - WIDTH = 16: 16 SHL edges -> exactly one frame_done pulse, and sout_msb reproduces the input sequence delayed by 16 edges.
